// File: rtl/sitcpxg_rx_stream_buffer.sv
// RX buffer manager for the SiTCP 10GbE core. It owns the RX RAM, tracks the write, fetch and read pointers,
// and streams committed bytes out as ready/valid beats. Beats are left-justified and never cross a word.
module sitcpxg_rx_stream_buffer #(
    parameter int ADDR_W = 16,
    parameter int FILL_W = ADDR_W + 1
) (
    input  logic              XGMII_CLOCK,
    input  logic              RSTn,
    input  logic [15:0]       USER_RX_WADR,
    input  logic [7:0]        USER_RX_WENB,
    input  logic [63:0]       USER_RX_WDAT,
    input  logic              USER_RX_CLR_ENB,
    output logic              USER_RX_CLR_REQ,
    output logic [15:0]       USER_RX_RADR,
    output logic [15:0]       USER_RX_SIZE,
    output logic [63:0]       RX_DATA,
    output logic [3:0]        RX_BYTES,
    output logic              RX_VALID,
    input  logic              RX_READY,
    input  logic              RX_FLUSH,
    output logic [FILL_W-1:0] FILL_LEVEL
);

    localparam int WORD_W = ADDR_W - 3;
    localparam int DEPTH  = 1 << WORD_W;
    localparam logic [15:0] SIZE_C = (ADDR_W >= 16) ? 16'd65520 : 16'((1 << ADDR_W) - 16);

    // One past the last byte written: the lowest-order enabled lane is the highest byte offset.
    function automatic logic [3:0] wr_end_off(input logic [7:0] wenb);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (wenb[i]) r = 4'(8 - i);
        end
        return r;
    endfunction

    function automatic logic [63:0] align_beat(input logic [63:0] word, input logic [2:0] off,
                                               input logic [3:0] n);
        logic [63:0] sh;
        logic [63:0] mask;
        sh   = word << {off, 3'b000};
        mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {n, 3'b000});
        return sh & mask;
    endfunction

    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wp, rp, fp;
    logic [WORD_W-1:0] wr_word;
    logic [ADDR_W-1:0] wp_next;
    logic              flush_pending;
    logic              clr_req;
    logic [FILL_W-1:0] fill_level;
    logic              wadr_unused;

    logic [ADDR_W-1:0] avail_p0;
    logic [3:0]        room_p0, bytes_p0;
    logic              halt_p0, issue_p0;
    logic [63:0]       ram_q_p1;
    logic [2:0]        off_p1;
    logic [3:0]        bytes_p1;
    logic              vld_p1, adv_p1;
    logic [63:0]       data_p2;
    logic [3:0]        bytes_p2;
    logic              vld_p2, xfer_p2;

    assign wadr_unused = ^USER_RX_WADR;
    assign wr_word     = USER_RX_WADR[ADDR_W-1:3];
    assign wp_next     = {wr_word, 3'b000} + ADDR_W'(wr_end_off(USER_RX_WENB));

    always_ff @(posedge XGMII_CLOCK) begin
        for (int k = 0; k < 8; k++) begin
            if (USER_RX_WENB[k]) mem[wr_word][8*k +: 8] <= USER_RX_WDAT[8*k +: 8];
        end
    end

    // Stage p0: choose the next beat from the fetch pointer, limited to the rest of its word.
    assign avail_p0 = wp - fp;
    assign room_p0  = 4'd8 - {1'b0, fp[2:0]};
    assign bytes_p0 = (avail_p0 < ADDR_W'(room_p0)) ? avail_p0[3:0] : room_p0;
    assign halt_p0  = flush_pending | RX_FLUSH;
    assign xfer_p2  = vld_p2 & RX_READY;
    assign adv_p1   = vld_p1 & (~vld_p2 | RX_READY);
    assign issue_p0 = ~halt_p0 & (avail_p0 != '0) & (~vld_p1 | adv_p1);

    // Stage p1: RAM word and beat shape, held while the output register is stalled.
    always_ff @(posedge XGMII_CLOCK) begin
        if (issue_p0) begin
            ram_q_p1 <= mem[fp[ADDR_W-1:3]];
            off_p1   <= fp[2:0];
            bytes_p1 <= bytes_p0;
        end
    end

    // Stage p2: output register plus all pointer and flush control.
    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) begin
            wp            <= '0;
            rp            <= '0;
            fp            <= '0;
            fill_level    <= '0;
            flush_pending <= 1'b0;
            clr_req       <= 1'b0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            data_p2       <= '0;
            bytes_p2      <= '0;
        end else begin
            clr_req    <= 1'b0;
            fill_level <= FILL_W'(wp - rp);
            if (|USER_RX_WENB) wp <= wp_next;
            if (xfer_p2) rp <= rp + ADDR_W'(bytes_p2);

            if (flush_pending && USER_RX_CLR_ENB) begin
                clr_req       <= 1'b1;
                rp            <= wp;
                fp            <= wp;
                flush_pending <= 1'b0;
                vld_p1        <= 1'b0;
                vld_p2        <= 1'b0;
                data_p2       <= '0;
                bytes_p2      <= '0;
            end else if (halt_p0) begin
                flush_pending <= 1'b1;
                vld_p1        <= 1'b0;
                vld_p2        <= 1'b0;
            end else begin
                if (issue_p0) begin
                    fp     <= fp + ADDR_W'(bytes_p0);
                    vld_p1 <= 1'b1;
                end else if (adv_p1) begin
                    vld_p1 <= 1'b0;
                end
                if (adv_p1) begin
                    vld_p2   <= 1'b1;
                    data_p2  <= align_beat(ram_q_p1, off_p1, bytes_p1);
                    bytes_p2 <= bytes_p1;
                end else if (xfer_p2) begin
                    vld_p2 <= 1'b0;
                end
            end
        end
    end

    assign RX_VALID        = vld_p2;
    assign RX_DATA         = data_p2;
    assign RX_BYTES        = bytes_p2;
    assign USER_RX_CLR_REQ = clr_req;
    assign USER_RX_RADR    = 16'(rp);
    assign USER_RX_SIZE    = SIZE_C;
    assign FILL_LEVEL      = fill_level;

endmodule

// File: tb/tb_sitcpxg_rx_stream_buffer.sv
// Scoreboard bench for sitcpxg_rx_stream_buffer: written bytes are queued as an ordered byte stream and
// every accepted beat is popped and compared, alongside a byte-level model of the read pointer.
module tb_sitcpxg_rx_stream_buffer;

    localparam int ADDR_W = 12;
    localparam int FILL_W = ADDR_W + 1;
    localparam int MASK   = (1 << ADDR_W) - 1;
    localparam int SIZE   = (1 << ADDR_W) - 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic [15:0]       wadr;
    logic [7:0]        wenb;
    logic [63:0]       wdat;
    logic              clr_enb;
    logic              clr_req;
    logic [15:0]       radr;
    logic [15:0]       rsize;
    logic [63:0]       rx_data;
    logic [3:0]        rx_bytes;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_flush;
    logic [FILL_W-1:0] fill;

    sitcpxg_rx_stream_buffer #(.ADDR_W(ADDR_W), .FILL_W(FILL_W)) dut (
        .XGMII_CLOCK(clk), .RSTn(rstn),
        .USER_RX_WADR(wadr), .USER_RX_WENB(wenb), .USER_RX_WDAT(wdat),
        .USER_RX_CLR_ENB(clr_enb), .USER_RX_CLR_REQ(clr_req),
        .USER_RX_RADR(radr), .USER_RX_SIZE(rsize),
        .RX_DATA(rx_data), .RX_BYTES(rx_bytes), .RX_VALID(rx_valid),
        .RX_READY(rx_ready), .RX_FLUSH(rx_flush), .FILL_LEVEL(fill)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         beat_log[$];
    int         rp_m = 0;
    int         wp_m = 0;
    int         beat_cnt = 0;
    int         clr_cnt = 0;
    bit         saw_wrap = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted beat pops its bytes from the expected stream.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            rp_m = 0;
        end else begin
            if (clr_req) begin
                clr_cnt++;
                exp_q.delete();
                rp_m = wp_m;
            end
            check("radr", 64'(radr), 64'(rp_m));
            if (rx_valid && rx_ready) begin
                int         nb;
                logic [63:0] e;
                nb = int'(rx_bytes);
                check("beat_bytes_bound", 64'(nb >= 1 && nb <= 8 - (rp_m % 8)), 64'd1);
                if (exp_q.size() < nb) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat_underflow: got %0d bytes, expected at most %0d", nb, exp_q.size());
                end else begin
                    e = '0;
                    for (int i = 0; i < nb; i++) e[63-8*i -: 8] = exp_q.pop_front();
                    check("beat_data", rx_data, e);
                end
                beat_log.push_back(nb);
                beat_cnt++;
                if (rp_m + nb > MASK) saw_wrap = 1;
                rp_m = (rp_m + nb) & MASK;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Core-style write of n contiguous bytes starting at the model write pointer.
    task automatic wr(input int n);
        int          o;
        logic [7:0]  en;
        logic [63:0] d;
        logic [7:0]  b;
        o  = wp_m % 8;
        d  = {$urandom, $urandom};
        en = '0;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            d[63-8*(o+i) -: 8] = b;
            en[7-(o+i)] = 1'b1;
            exp_q.push_back(b);
        end
        wadr = 16'(wp_m & ~7) | 16'($urandom_range(0, 15) << 12);
        wenb = en;
        wdat = d;
        @(posedge clk);
        #1;
        wenb = '0;
        wp_m = (wp_m + n) & MASK;
    endtask

    logic [63:0] d0;
    logic [3:0]  b0;
    int          s, k, pulses, written, budget;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 0; wadr = '0; wenb = '0; wdat = '0; clr_enb = 0; rx_ready = 0; rx_flush = 0;
        cyc(3);
        check("rst_valid", 64'(rx_valid), 64'd0);
        check("rst_data", rx_data, 64'd0);
        check("rst_bytes", 64'(rx_bytes), 64'd0);
        check("rst_clr_req", 64'(clr_req), 64'd0);
        check("rst_radr", 64'(radr), 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        check("size", 64'(rsize), 64'(SIZE));
        rstn = 1;
        cyc(2);

        // Three full words back to back, first beat three cycles after the first write.
        rx_ready = 1;
        s = beat_cnt;
        fork
            begin wr(8); wr(8); wr(8); end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk) check("t1_before_latency", 64'(rx_valid), 64'd0);
                @(negedge clk) check("t1_beat0_valid", 64'(rx_valid), 64'd1);
                @(negedge clk) check("t1_beat1_valid", 64'(rx_valid), 64'd1);
                @(negedge clk) check("t1_beat2_valid", 64'(rx_valid), 64'd1);
            end
        join
        cyc(4);
        check("t1_beats", 64'(beat_cnt - s), 64'd3);
        check("t1_radr", 64'(radr), 64'd24);
        check("t1_fill", 64'(fill), 64'd0);

        // Half word, then the other half two cycles later.
        s = beat_log.size();
        wr(4); cyc(1); wr(4);
        cyc(6);
        check("t2_beat_count", 64'(beat_log.size() - s), 64'd2);
        if (beat_log.size() - s == 2) begin
            check("t2_first_bytes", 64'(beat_log[s]), 64'd4);
            check("t2_second_bytes", 64'(beat_log[s+1]), 64'd4);
        end
        check("t2_radr", 64'(radr), 64'd32);

        // Stall with 24 bytes committed, then release.
        rx_ready = 0;
        wr(8); wr(8); wr(8);
        cyc(4);
        @(negedge clk);
        check("t4_fill", 64'(fill), 64'd24);
        check("t4_valid", 64'(rx_valid), 64'd1);
        check("t4_bytes", 64'(rx_bytes), 64'd8);
        d0 = rx_data;
        b0 = rx_bytes;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("t4_hold", {rx_data[63:5], rx_bytes, rx_valid}, {d0[63:5], b0, 1'b1});
        end
        @(posedge clk); #1;
        rx_ready = 1;
        s = beat_cnt;
        for (int i = 0; i < 3; i++) @(negedge clk) check("t4_release_valid", 64'(rx_valid), 64'd1);
        cyc(3);
        check("t4_beats", 64'(beat_cnt - s), 64'd3);
        check("t4_fill_after", 64'(fill), 64'd0);

        // Flush with 40 bytes buffered while the core withholds the clear enable.
        rx_ready = 0;
        for (int i = 0; i < 5; i++) wr(8);
        cyc(4);
        check("t5_valid_before", 64'(rx_valid), 64'd1);
        check("t5_fill_before", 64'(fill), 64'd40);
        rx_flush = 1;
        cyc(1);
        rx_flush = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_valid_pending", 64'(rx_valid), 64'd0);
            check("t5_clr_req_pending", 64'(clr_req), 64'd0);
            @(posedge clk); #1;
            rx_flush = (i == 2);
        end
        rx_flush = 0;
        clr_enb = 1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (clr_req) pulses++;
            check("t5_valid_clear", 64'(rx_valid), 64'd0);
        end
        check("t5_clr_pulses", 64'(pulses), 64'd1);
        @(posedge clk); #1;
        clr_enb = 0;
        cyc(2);
        check("t5_radr", 64'(radr), 64'(wp_m));
        check("t5_fill", 64'(fill), 64'd0);
        rx_ready = 1;
        s = beat_cnt;
        wr(8);
        cyc(5);
        check("t5_resume_beats", 64'(beat_cnt - s), 64'd1);

        // Random stream across the buffer wrap with a randomly toggled ready.
        written = 0;
        while (written < 4600) begin
            rx_ready = ($urandom_range(0, 3) != 0);
            k = 8 - (wp_m % 8);
            if ($urandom_range(0, 1) == 0) k = $urandom_range(1, k);
            if ($urandom_range(0, 4) != 0 && exp_q.size() + k <= SIZE) begin
                wr(k);
                written += k;
            end else begin
                cyc(1);
            end
        end
        rx_ready = 1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 3000) begin
            cyc(1);
            budget++;
        end
        if (budget >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL t3_drain: got %0d bytes left, expected 0", exp_q.size());
        end
        cyc(3);
        check("t3_wrapped", 64'(saw_wrap), 64'd1);
        check("t3_fill", 64'(fill), 64'd0);
        check("t3_radr", 64'(radr), 64'(wp_m));

        // Reset during a held beat and a pending flush.
        rx_ready = 0;
        wr(8); wr(8);
        cyc(4);
        check("t6_valid_before", 64'(rx_valid), 64'd1);
        rx_flush = 1;
        cyc(1);
        rx_flush = 0;
        cyc(2);
        #3;
        rstn = 0;
        #1;
        check("t6_valid", 64'(rx_valid), 64'd0);
        check("t6_data", rx_data, 64'd0);
        check("t6_bytes", 64'(rx_bytes), 64'd0);
        check("t6_radr", 64'(radr), 64'd0);
        check("t6_fill", 64'(fill), 64'd0);
        check("t6_clr_req", 64'(clr_req), 64'd0);
        check("t6_size", 64'(rsize), 64'(SIZE));
        wp_m = 0;
        cyc(2);
        rstn = 1;
        clr_enb = 1;
        s = clr_cnt;
        cyc(6);
        check("t6_no_clr_req", 64'(clr_cnt - s), 64'd0);
        clr_enb = 0;
        rx_ready = 1;
        s = beat_cnt;
        wr(8);
        cyc(5);
        check("t6_after_reset_beats", 64'(beat_cnt - s), 64'd1);
        check("t6_after_reset_radr", 64'(radr), 64'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sitcpxg_rx_stream_buffer.md
Name: sitcpxg_rx_stream_buffer

Overview:
Parametrised receive-buffer manager for the 10GbE SiTCP core's TCP RX memory interface. It owns the dual-port RX RAM of 2^ADDR_W bytes and absorbs the core's byte-enabled 64-bit writes. It tracks committed and consumed byte pointers, drives the read pointer and size back to the core, and presents received data to user logic as a ready/valid byte stream. It also adds a user-initiated flush that runs through the core's clear handshake.

Parameters:
ADDR_W, 16, byte-address width; RAM = 2^(ADDR_W-3) words x 64 bit; legal range 12..16
FILL_W, ADDR_W+1, width of FILL_LEVEL output

Ports:
XGMII_CLOCK  in  1  single clock for all logic
RSTn  in  1  asynchronous active-low reset
USER_RX_WADR  in  16  core write byte address; bits [2:0] ignored; bits above ADDR_W-1 ignored
USER_RX_WENB  in  8  core byte write enable, big endian (bit7 = WDAT[63:56] = byte offset 0)
USER_RX_WDAT  in  64  core write data, big endian
USER_RX_CLR_ENB  in  1  core permits a buffer clear
USER_RX_CLR_REQ  out  1  clear request pulse to core
USER_RX_RADR  out  16  consumed byte pointer; upper 16-ADDR_W bits are 0
USER_RX_SIZE  out  16  constant 2^ADDR_W-16, saturated to 65520 at ADDR_W=16
RX_DATA  out  64  output bytes, left-justified big endian
RX_BYTES  out  4  valid byte count, 1..8
RX_VALID  out  1  output beat valid
RX_READY  in  1  user accepts beat
RX_FLUSH  in  1  user request to discard all buffered data (pulse)
FILL_LEVEL  out  FILL_W  committed-but-unconsumed byte count

Behaviour:
- Reset (RSTn low, async): wp=0, rp=0, RX_VALID=0, RX_DATA=0, RX_BYTES=0, USER_RX_CLR_REQ=0, USER_RX_RADR=0, FILL_LEVEL=0, flush_pending=0. USER_RX_SIZE is constant and unaffected. RAM contents are undefined.
- Write path: any cycle with WENB!=0 writes the enabled bytes to word WADR[ADDR_W-1:3].
  - wp <= {WADR[ADDR_W-1:3],3'b000} + (position of lowest-order set WENB bit counted from bit7, +1), modulo 2^ADDR_W.
  - Core writes contiguously in order. The block does not check for gaps.
- Fill: FILL_LEVEL = (wp - rp) mod 2^ADDR_W, registered, updated the cycle after any wp/rp change. The core never exceeds USER_RX_SIZE, so fill==0 always means empty.
- Read path: synchronous RAM read with 1-cycle latency, followed by an output register (skid). States:
  - EMPTY: RX_VALID=0.
  - FETCH: address issued.
  - VALID: beat held.
- Beat formation:
  - RX_BYTES = min(8 - rp[2:0], fill).
  - RX_DATA holds bytes rp..rp+RX_BYTES-1 shifted to [63:...]. Unused low bytes are 0.
  - A beat never crosses a word boundary.
- Handshake:
  - Beat transfers when RX_VALID&RX_READY.
  - RX_DATA and RX_BYTES are stable while RX_VALID&!RX_READY.
  - On transfer, rp += RX_BYTES (mod 2^ADDR_W) and USER_RX_RADR updates the next cycle.
  - Next word is prefetched, so back-to-back full words sustain 1 beat/cycle with RX_READY held high.
- Partial word growth: if a beat is held with RX_BYTES<8-rp[2:0] and new bytes commit to the same word, the held beat is not altered. The extra bytes appear in a following beat.
- Latency: first byte written at cycle T (buffer empty, RX_READY=1) gives RX_VALID=1 at T+3.
- Simultaneous write and transfer in the same cycle: both pointers update; FILL_LEVEL reflects both.
- Flush:
  - RX_FLUSH sets flush_pending. RX_VALID is forced 0 the next cycle and no further beats are issued.
  - When flush_pending & USER_RX_CLR_ENB: USER_RX_CLR_REQ=1 for exactly one cycle, rp <= wp, output register cleared, flush_pending cleared.
  - A further RX_FLUSH while pending has no additional effect.
  - If CLR_ENB stays low, the block waits indefinitely.
- Reset mid-operation: all state returns to reset values immediately; no CLR_REQ is generated.

Test Plan:
1. Core writes 3 full words at WADR 0,8,16 (WENB=FF), RX_READY=1 -> beats of 8 bytes at T+3..T+5 with data matching; USER_RX_RADR 8,16,24; FILL_LEVEL returns to 0.
2. Write WENB=F0 at WADR 0, then WENB=0F at WADR 0 two cycles later -> first beat RX_BYTES=4 = bytes 0..3; second beat RX_BYTES=4 = bytes 4..7; RADR ends at 8.
3. ADDR_W=12: stream 4080 bytes crossing wrap at 4096, RX_READY toggled randomly -> USER_RX_SIZE=4080; data in order; rp wraps 4088->0; no beat spans the wrap.
4. RX_READY low for 10 cycles with 24 bytes committed -> RX_DATA/RX_BYTES stable; FILL_LEVEL=24; release gives 3 beats on consecutive cycles.
5. 40 bytes buffered, pulse RX_FLUSH with CLR_ENB=0 for 5 cycles then 1 -> RX_VALID=0 throughout; single-cycle CLR_REQ on first CLR_ENB cycle; RADR=wp=40; FILL_LEVEL=0.
6. Assert RSTn low during a held beat and a pending flush -> all outputs 0 asynchronously; no CLR_REQ after release.
